load_store_unit: RTL and testbench

Core-side front end for the byte-addressable data memory. It accepts one load or store request at a time from the execute stage and checks alignment and range. It drives the memory's address / write_mode / write-data inputs and sequences the memory's done handshake. It then returns one registered response carrying sign- or zero-extended load data or an error code.

---
 rtl/load_store_unit.sv | 264 ++++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Core-side front end for the byte-addressable data memory. Accepts one load
//   or store at a time, checks alignment and range, drives the memory address /
//   write_mode / write-data inputs, sequences the memory done handshake and
//   returns one registered response with extended load data or an error code.
//
//   Optional feature macro: LSU_TIMEOUT_EN (store watchdog, error code 3).
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_*                 request from execute stage; req_ready = IDLE && !mem_done
//   resp_valid/rdata/error one-cycle registered response
//                         error: 0=ok, 1=misaligned, 2=out-of-range, 3=timeout
//   mem_address, mem_write_mode, mem_write_byte/half_word/word  to memory
//   mem_done, mem_byte, mem_half_word, mem_word                 from memory
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_BITS      = 18,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_error,
    output logic [31:0] mem_address,
    output logic [1:0]  mem_write_mode,
    output logic [7:0]  mem_write_byte,
    output logic [15:0] mem_write_half_word,
    output logic [31:0] mem_write_word,
    input  logic        mem_done,
    input  logic [7:0]  mem_byte,
    input  logic [15:0] mem_half_word,
    input  logic [31:0] mem_word
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_WAIT  = 2'd1,
        STORE_WAIT = 2'd2,
        RELEASE    = 2'd3
    } state_t;

    // Parameter sanity: the range slice needs 1..31, the watchdog is 8 bits.
    if (ADDR_BITS < 1 || ADDR_BITS > 31) begin : g_bad_addr_bits
        $error("ADDR_BITS must be in 1..31");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    state_t      state_r, next_state_s;

    logic        req_ready_s, accept_s, misaligned_s, out_of_range_s;
    logic [1:0]  eff_size_s;
    logic        latch_s, store_go_s, store_end_s;
    logic        fsm_resp_s, resp_load_s, err_pend_set_s;
    logic [1:0]  fsm_err_s, err_code_s;
    logic        resp_set_s;
    logic [1:0]  resp_err_s;
    logic [31:0] load_data_s;
    logic        timeout_hit_s, timed_out_s;

    logic [1:0]  size_r;
    logic        signed_r;
    logic [31:0] address_r;
    logic [31:0] wdata_r;
    logic [1:0]  mode_r;
    logic        load_cnt_r;
    logic        err_pend_r;
    logic [1:0]  err_code_r;
    logic        resp_valid_r;
    logic [31:0] resp_rdata_r;
    logic [1:0]  resp_error_r;

    // Size 0 is an alias for word.
    assign eff_size_s     = (req_size == 2'd0) ? 2'd3 : req_size;
    assign misaligned_s   = ((eff_size_s == 2'd2) && req_address[0]) ||
                            ((eff_size_s == 2'd3) && (req_address[1:0] != 2'd0));
    assign out_of_range_s = |req_address[31:ADDR_BITS];
    // A memory still reporting done (e.g. after a reset mid-store) blocks new work.
    assign req_ready_s    = (state_r == IDLE) && !mem_done;
    assign accept_s       = req_valid && req_ready_s;

    // Error responses come out one cycle after accept through err_pend_r; they
    // cannot collide with an FSM response because an error leaves the FSM in IDLE.
    assign resp_set_s = fsm_resp_s | err_pend_r;
    assign resp_err_s = err_pend_r ? err_code_r : fsm_err_s;

    // Load data selection and sign/zero extension from the registered request.
    always_comb begin
        load_data_s = mem_word;
        case (size_r)
            2'd1:    load_data_s = signed_r ? {{24{mem_byte[7]}}, mem_byte}
                                            : {24'd0, mem_byte};
            2'd2:    load_data_s = signed_r ? {{16{mem_half_word[15]}}, mem_half_word}
                                            : {16'd0, mem_half_word};
            default: load_data_s = mem_word;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        next_state_s   = state_r;
        latch_s        = 1'b0;
        store_go_s     = 1'b0;
        store_end_s    = 1'b0;
        fsm_resp_s     = 1'b0;
        fsm_err_s      = 2'd0;
        resp_load_s    = 1'b0;
        err_pend_set_s = 1'b0;
        err_code_s     = 2'd0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (misaligned_s) begin
                        err_pend_set_s = 1'b1;
                        err_code_s     = 2'd1;
                    end else if (out_of_range_s) begin
                        err_pend_set_s = 1'b1;
                        err_code_s     = 2'd2;
                    end else begin
                        latch_s = 1'b1;
                        if (req_store) begin
                            store_go_s   = 1'b1;
                            next_state_s = STORE_WAIT;
                        end else begin
                            next_state_s = LOAD_WAIT;
                        end
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD_WAIT: begin
                // Synchronous memory: data is valid at the second edge after accept.
                if (load_cnt_r) begin
                    fsm_resp_s   = 1'b1;
                    resp_load_s  = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = LOAD_WAIT;
                end
            end
            STORE_WAIT: begin
                if (mem_done) begin
                    store_end_s  = 1'b1;
                    next_state_s = RELEASE;
                end else if (timeout_hit_s) begin
                    store_end_s  = 1'b1;
                    next_state_s = RELEASE;
                end else begin
                    next_state_s = STORE_WAIT;
                end
            end
            RELEASE: begin
                if (!mem_done) begin
                    fsm_resp_s   = 1'b1;
                    fsm_err_s    = timed_out_s ? 2'd3 : 2'd0;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RELEASE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Request capture, memory drive registers and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_r       <= 2'd0;
            signed_r     <= 1'b0;
            address_r    <= 32'd0;
            wdata_r      <= 32'd0;
            mode_r       <= 2'd0;
            load_cnt_r   <= 1'b0;
            err_pend_r   <= 1'b0;
            err_code_r   <= 2'd0;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_error_r <= 2'd0;
        end else begin
            resp_valid_r <= resp_set_s;
            resp_error_r <= resp_err_s;
            resp_rdata_r <= resp_load_s ? load_data_s : 32'd0;
            err_pend_r   <= err_pend_set_s;
            err_code_r   <= err_code_s;
            if (latch_s) begin
                size_r    <= eff_size_s;
                signed_r  <= req_signed;
                address_r <= req_address;
                wdata_r   <= req_wdata;
            end
            if (store_go_s) begin
                mode_r <= eff_size_s;
            end else if (store_end_s) begin
                mode_r <= 2'd0;
            end
            if (latch_s) begin
                load_cnt_r <= 1'b0;
            end else if (state_r == LOAD_WAIT) begin
                load_cnt_r <= ~load_cnt_r;
            end
        end
    end

`ifdef LSU_TIMEOUT_EN
    logic [7:0] wd_cnt_r;
    logic       timed_out_r;

    assign timeout_hit_s = (wd_cnt_r == 8'(TIMEOUT_CYCLES - 1));
    assign timed_out_s   = timed_out_r;

    // Store watchdog: counts cycles spent in STORE_WAIT, flags a timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_r    <= 8'd0;
            timed_out_r <= 1'b0;
        end else if (store_go_s) begin
            wd_cnt_r    <= 8'd0;
            timed_out_r <= 1'b0;
        end else if (state_r == STORE_WAIT) begin
            wd_cnt_r <= wd_cnt_r + 8'd1;
            if (!mem_done && timeout_hit_s) begin
                timed_out_r <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit_s = 1'b0;
    assign timed_out_s   = 1'b0;
`endif

    assign req_ready           = req_ready_s;
    assign resp_valid          = resp_valid_r;
    assign resp_rdata          = resp_rdata_r;
    assign resp_error          = resp_error_r;
    assign mem_address         = address_r;
    assign mem_write_mode      = mode_r;
    assign mem_write_byte      = wdata_r[7:0];
    assign mem_write_half_word = wdata_r[15:0];
    assign mem_write_word      = wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Directed bench for load_store_unit with a big-endian byte-array memory stub
//   and a byte-level reference model that predicts each response (data, error
//   code and, where fixed, the cycle it appears in).
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_store, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_address, req_wdata;
    logic        req_ready, resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_error;
    logic [31:0] mem_address;
    logic [1:0]  mem_write_mode;
    logic [7:0]  mem_write_byte;
    logic [15:0] mem_write_half_word;
    logic [31:0] mem_write_word;
    logic        mem_done = 1'b0;
    logic [7:0]  mem_byte = 8'd0;
    logic [15:0] mem_half_word = 16'd0;
    logic [31:0] mem_word = 32'd0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_signed(req_signed), .req_address(req_address),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_address(mem_address), .mem_write_mode(mem_write_mode),
        .mem_write_byte(mem_write_byte), .mem_write_half_word(mem_write_half_word),
        .mem_write_word(mem_write_word),
        .mem_done(mem_done), .mem_byte(mem_byte), .mem_half_word(mem_half_word),
        .mem_word(mem_word)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory stub (big-endian lanes, synchronous read) --------
    logic [7:0] m [0:1023];
    wire  [9:0] ai = mem_address[9:0];
    int   st_cnt = 0;
    int   rel_cnt = 0;
    int   done_delay = 2;
    int   release_delay = 1;
    bit   stub_hang = 1'b0;

    always @(posedge clk) begin
        mem_byte      <= m[ai];
        mem_half_word <= {m[ai], m[ai + 10'd1]};
        mem_word      <= {m[ai], m[ai + 10'd1], m[ai + 10'd2], m[ai + 10'd3]};
        if (mem_write_mode != 2'd0) begin
            rel_cnt <= 0;
            if (!mem_done) begin
                if (st_cnt >= done_delay && !stub_hang) begin
                    mem_done <= 1'b1;
                    st_cnt   <= 0;
                    case (mem_write_mode)
                        2'd1: m[ai] <= mem_write_byte;
                        2'd2: begin
                            m[ai]         <= mem_write_half_word[15:8];
                            m[ai + 10'd1] <= mem_write_half_word[7:0];
                        end
                        default: begin
                            m[ai]         <= mem_write_word[31:24];
                            m[ai + 10'd1] <= mem_write_word[23:16];
                            m[ai + 10'd2] <= mem_write_word[15:8];
                            m[ai + 10'd3] <= mem_write_word[7:0];
                        end
                    endcase
                end else begin
                    st_cnt <= st_cnt + 1;
                end
            end
        end else begin
            st_cnt <= 0;
            if (mem_done) begin
                if (rel_cnt >= release_delay) begin
                    mem_done <= 1'b0;
                    rel_cnt  <= 0;
                end else begin
                    rel_cnt <= rel_cnt + 1;
                end
            end
        end
    end

    // ---------------- reference model ----------------------------------------
    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          due;   // expected observation cycle, -1 = not fixed
    } exp_t;

    exp_t       expq [$];
    logic [7:0] ref_mem [0:1023];

    function automatic void model_accept(input bit st, input logic [1:0] sz, input bit sg,
                                         input logic [31:0] a, input logic [31:0] wd,
                                         input bit hang, input int acc);
        exp_t        e;
        int          n;
        logic [31:0] v;
        n       = (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : 4;
        e.rdata = 32'd0;
        e.err   = 2'd0;
        e.due   = -1;
        if ((a % n) != 0) begin
            e.err = 2'd1;
            e.due = acc + 1;
        end else if (a >= 32'h0004_0000) begin
            e.err = 2'd2;
            e.due = acc + 1;
        end else if (st) begin
            if (hang) begin
                e.err = 2'd3;
            end else begin
                for (int k = 0; k < n; k++)
                    ref_mem[(a[9:0] + k) % 1024] = 8'((wd >> (8 * (n - 1 - k))) & 32'hFF);
            end
        end else begin
            v = 32'd0;
            for (int k = 0; k < n; k++)
                v = (v << 8) | {24'd0, ref_mem[(a[9:0] + k) % 1024]};
            if (sg && n < 4 && ((v >> (8 * n - 1)) & 32'd1) == 32'd1)
                v = v | (32'hFFFF_FFFF << (8 * n));
            e.rdata = v;
            e.due   = acc + 2;
        end
        expq.push_back(e);
    endfunction

    // ---------------- compare process -----------------------------------------
    logic [31:0] last_rdata = 32'd0;
    logic [1:0]  last_err = 2'd0;
    int          resp_seen = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && resp_valid) begin
            tests++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_resp: resp_valid with nothing outstanding, rdata=%h err=%0d",
                         resp_rdata, resp_error);
            end else begin
                e = expq.pop_front();
                if (resp_rdata !== e.rdata || resp_error !== e.err ||
                    (e.due >= 0 && cyc != e.due)) begin
                    fails++;
                    $display("FAIL resp: got rdata=%h err=%0d cyc=%0d, want rdata=%h err=%0d cyc=%0d",
                             resp_rdata, resp_error, cyc, e.rdata, e.err, e.due);
                end
            end
            last_rdata = resp_rdata;
            last_err   = resp_error;
            resp_seen++;
        end
    end

    // ---------------- helpers --------------------------------------------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Issue one request (called away from the rising edge) and wait for its response.
    task automatic do_req(input bit st, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd, input bit hang,
                          output logic [31:0] rd, output logic [1:0] er,
                          output logic [1:0] md, output bit hold_bad);
        int n0;
        int w;
        rd = 32'd0; er = 2'd0; md = 2'd0; hold_bad = 1'b0;
        w = 0;
        while (!req_ready && w < 200) begin
            @(negedge clk); #1;
            w++;
        end
        tests++;
        if (!req_ready) begin
            fails++;
            $display("FAIL ready_timeout: req_ready=%b, want 1", req_ready);
            return;
        end
        req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg;
        req_address = a; req_wdata = wd;
        n0 = resp_seen;
        @(posedge clk); #1;
        model_accept(st, sz, sg, a, wd, hang, cyc);
        req_valid = 1'b0;
        w = 0;
        while (resp_seen == n0 && w < 300) begin
            md = md | mem_write_mode;
            if (mem_write_mode != 2'd0 &&
                (mem_address !== a || mem_write_word !== wd ||
                 mem_write_half_word !== wd[15:0] || mem_write_byte !== wd[7:0]))
                hold_bad = 1'b1;
            @(negedge clk); #1;
            w++;
        end
        tests++;
        if (resp_seen == n0) begin
            fails++;
            $display("FAIL resp_timeout: no response after %0d cycles, want one", w);
        end else begin
            rd = last_rdata;
            er = last_err;
        end
    endtask

    // ---------------- directed sequence ----------------------------------------
    logic [31:0] rd;
    logic [1:0]  er, md;
    bit          hb;

    initial begin
        req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_address = 32'd0; req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mode", {30'd0, mem_write_mode}, 32'd0);
        check("rst_mem_address", mem_address, 32'd0);
        check("rst_wdata", mem_write_word, 32'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("ready_after_reset", {31'd0, req_ready}, 32'd1);

        // Word store then word load.
        do_req(1'b1, 2'd3, 1'b0, 32'h100, 32'hDEAD_BEEF, 1'b0, rd, er, md, hb);
        check("st_word_err", {30'd0, er}, 32'd0);
        check("st_word_mode", {30'd0, md}, 32'd3);
        check("st_word_hold", {31'd0, hb}, 32'd0);
        do_req(1'b0, 2'd3, 1'b0, 32'h100, 32'd0, 1'b0, rd, er, md, hb);
        check("ld_word", rd, 32'hDEAD_BEEF);
        check("ld_word_mode", {30'd0, md}, 32'd0);

        // Half store into the low half of the word, reload.
        do_req(1'b1, 2'd2, 1'b0, 32'h102, 32'hAAAA_1234, 1'b0, rd, er, md, hb);
        check("st_half_mode", {30'd0, md}, 32'd2);
        check("st_half_hold", {31'd0, hb}, 32'd0);
        do_req(1'b0, 2'd0, 1'b0, 32'h100, 32'd0, 1'b0, rd, er, md, hb);
        check("ld_word_size0", rd, 32'hDEAD_1234);
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 1'b0, rd, er, md, hb);
        check("ld_half_u", rd, 32'h0000_DEAD);
        do_req(1'b0, 2'd2, 1'b1, 32'h100, 32'd0, 1'b0, rd, er, md, hb);
        check("ld_half_s", rd, 32'hFFFF_DEAD);

        // Byte store, signed and unsigned byte loads.
        do_req(1'b1, 2'd1, 1'b0, 32'h104, 32'h1234_5680, 1'b0, rd, er, md, hb);
        check("st_byte_mode", {30'd0, md}, 32'd1);
        do_req(1'b0, 2'd1, 1'b1, 32'h104, 32'd0, 1'b0, rd, er, md, hb);
        check("ld_byte_s", rd, 32'hFFFF_FF80);
        do_req(1'b0, 2'd1, 1'b0, 32'h104, 32'd0, 1'b0, rd, er, md, hb);
        check("ld_byte_u", rd, 32'h0000_0080);

        // Error cases.
        do_req(1'b0, 2'd3, 1'b0, 32'h6, 32'd0, 1'b0, rd, er, md, hb);
        check("mis_word_err", {30'd0, er}, 32'd1);
        check("mis_word_mode", {30'd0, md}, 32'd0);
        do_req(1'b1, 2'd2, 1'b0, 32'h101, 32'hFFFF_FFFF, 1'b0, rd, er, md, hb);
        check("mis_half_st_err", {30'd0, er}, 32'd1);
        check("mis_half_st_mode", {30'd0, md}, 32'd0);
        do_req(1'b0, 2'd3, 1'b0, 32'h0004_0000, 32'd0, 1'b0, rd, er, md, hb);
        check("oor_err", {30'd0, er}, 32'd2);
        do_req(1'b1, 2'd3, 1'b0, 32'h0004_0002, 32'd1, 1'b0, rd, er, md, hb);
        check("mis_over_oor_err", {30'd0, er}, 32'd1);
        check("mis_over_oor_mode", {30'd0, md}, 32'd0);

        // Highest in-range byte.
        do_req(1'b1, 2'd1, 1'b0, 32'h0003_FFFF, 32'h0000_005A, 1'b0, rd, er, md, hb);
        check("top_st_err", {30'd0, er}, 32'd0);
        do_req(1'b0, 2'd1, 1'b1, 32'h0003_FFFF, 32'd0, 1'b0, rd, er, md, hb);
        check("top_ld", rd, 32'h0000_005A);

        // Reset in the middle of a word store while the memory reports done.
        done_delay = 1;
        release_delay = 4;
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'd3; req_signed = 1'b0;
        req_address = 32'h300; req_wdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midstore_mode", {30'd0, mem_write_mode}, 32'd3);
        check("midstore_done", {31'd0, mem_done}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_mode", {30'd0, mem_write_mode}, 32'd0);
        check("rst_ready_gated", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int w = 0; w < 50 && mem_done; w++) begin
            check("ready_low_while_done", {31'd0, req_ready}, 32'd0);
            @(negedge clk); #1;
        end
        check("done_dropped", {31'd0, mem_done}, 32'd0);
        check("ready_after_done_drop", {31'd0, req_ready}, 32'd1);
        done_delay = 2;
        release_delay = 1;
        do_req(1'b1, 2'd3, 1'b0, 32'h200, 32'hCAFE_0123, 1'b0, rd, er, md, hb);
        check("post_rst_store_err", {30'd0, er}, 32'd0);
        do_req(1'b0, 2'd3, 1'b0, 32'h200, 32'd0, 1'b0, rd, er, md, hb);
        check("post_rst_load", rd, 32'hCAFE_0123);

`ifdef LSU_TIMEOUT_EN
        stub_hang = 1'b1;
        do_req(1'b1, 2'd3, 1'b0, 32'h80, 32'h1111_2222, 1'b1, rd, er, md, hb);
        check("timeout_err", {30'd0, er}, 32'd3);
        stub_hang = 1'b0;
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", expq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1, "time limit");
    end

endmodule
